backend_cmd_arbiter: RTL and testbench

//  Shares the single backend command port (Command/PAddr/CurrentLeaf/RemappedLeaf,

---
 rtl/backend_cmd_arbiter.sv | 156 +++++++++++++++
 tb/tb_backend_cmd_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/backend_cmd_arbiter.sv
// backend_cmd_arbiter
//   Shares the single backend command port between two requesters:
//     A = frontend ORAM command queue, B = background requester (evictions,
//     maintenance). One command is granted at a time. The winner's fields are
//     registered and held stable until the backend reports CommandDone. The
//     done pulse is then routed back to the requester that owned the command.
//     A starvation counter bounds how long B can wait behind A.
//
// Ports
//   Clock, Reset          clock; synchronous active-high reset
//   A_* / B_*             requester command, address, leaves, valid (inputs);
//                         ready (accept, combinational), done (1-cycle pulse)
//   B_Pause               while high, B is never granted (A unaffected)
//   Command, PAddr,
//   CurrentLeaf,
//   RemappedLeaf          registered command fields to the backend
//   CommandRequest        high while a command is held for the backend
//   CommandDone           backend completion pulse
//   Owner                 0 = A, 1 = B owns the current command
module backend_cmd_arbiter #(
    parameter int BECMDWidth  = 2,
    parameter int ORAMU       = 32,
    parameter int ORAML       = 32,
    parameter int StarveLimit = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,

    input  logic [BECMDWidth-1:0] A_Command,
    input  logic [ORAMU-1:0]      A_PAddr,
    input  logic [ORAML-1:0]      A_CurrentLeaf,
    input  logic [ORAML-1:0]      A_RemappedLeaf,
    input  logic                  A_Valid,
    output logic                  A_Ready,
    output logic                  A_Done,

    input  logic [BECMDWidth-1:0] B_Command,
    input  logic [ORAMU-1:0]      B_PAddr,
    input  logic [ORAML-1:0]      B_CurrentLeaf,
    input  logic [ORAML-1:0]      B_RemappedLeaf,
    input  logic                  B_Valid,
    output logic                  B_Ready,
    output logic                  B_Done,
    input  logic                  B_Pause,

    output logic [BECMDWidth-1:0] Command,
    output logic [ORAMU-1:0]      PAddr,
    output logic [ORAML-1:0]      CurrentLeaf,
    output logic [ORAML-1:0]      RemappedLeaf,
    output logic                  CommandRequest,
    input  logic                  CommandDone,
    output logic                  Owner
);

    localparam logic [7:0] STARVE_MAX = 8'(StarveLimit);

    typedef enum logic {
        ST_Idle = 1'b0,
        ST_Busy = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_owner;
    logic [BECMDWidth-1:0]   r_command;
    logic [ORAMU-1:0]        r_paddr;
    logic [ORAML-1:0]        r_cur_leaf;
    logic [ORAML-1:0]        r_rem_leaf;
    logic [7:0]              r_starve_cnt;

    logic                    w_grant_a;
    logic                    w_grant_b;
    logic                    w_a_done;
    logic                    w_b_done;
    logic                    w_b_waiting;

    // B only counts as waiting when it is actually eligible for a grant.
    assign w_b_waiting = B_Valid & ~B_Pause;

    // Next-state / grant / done decode. Everything is gated by Reset so that a
    // reset cycle never produces a Ready or a Done pulse.
    always_comb begin
        w_state_next = r_state;
        w_grant_a    = 1'b0;
        w_grant_b    = 1'b0;
        w_a_done     = 1'b0;
        w_b_done     = 1'b0;
        case (r_state)
            ST_Idle: begin
                if (!Reset) begin
                    w_grant_b = w_b_waiting &
                                (~A_Valid | (r_starve_cnt == STARVE_MAX));
                    w_grant_a = A_Valid & ~w_grant_b;
                    if (w_grant_a || w_grant_b) begin
                        w_state_next = ST_Busy;
                    end
                end
            end
            ST_Busy: begin
                // No new grant can happen in the Done cycle; the earliest
                // next grant is the following cycle, leaving a request gap.
                if (!Reset && CommandDone) begin
                    w_a_done     = ~r_owner;
                    w_b_done     = r_owner;
                    w_state_next = ST_Idle;
                end
            end
            default: w_state_next = ST_Idle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= ST_Idle;
            r_owner      <= 1'b0;
            r_command    <= '0;
            r_paddr      <= '0;
            r_cur_leaf   <= '0;
            r_rem_leaf   <= '0;
            r_starve_cnt <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_a) begin
                r_owner    <= 1'b0;
                r_command  <= A_Command;
                r_paddr    <= A_PAddr;
                r_cur_leaf <= A_CurrentLeaf;
                r_rem_leaf <= A_RemappedLeaf;
            end else if (w_grant_b) begin
                r_owner    <= 1'b1;
                r_command  <= B_Command;
                r_paddr    <= B_PAddr;
                r_cur_leaf <= B_CurrentLeaf;
                r_rem_leaf <= B_RemappedLeaf;
            end
            // Count A grants that B was eligible to compete for; saturate.
            if (w_grant_b) begin
                r_starve_cnt <= 8'd0;
            end else if (w_grant_a && w_b_waiting && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    assign A_Ready        = w_grant_a;
    assign B_Ready        = w_grant_b;
    assign A_Done         = w_a_done;
    assign B_Done         = w_b_done;
    assign CommandRequest = (r_state == ST_Busy);
    assign Owner          = r_owner;
    assign Command        = r_command;
    assign PAddr          = r_paddr;
    assign CurrentLeaf    = r_cur_leaf;
    assign RemappedLeaf   = r_rem_leaf;

endmodule

// File: tb/tb_backend_cmd_arbiter.sv
// tb_backend_cmd_arbiter
//   Scoreboard bench for backend_cmd_arbiter. The driver applies inputs just
//   after each rising edge and runs a transaction-level model of the arbiter
//   rules, pushing expected grants and done pulses into queues. A monitor on
//   the falling edge pops those queues whenever the DUT presents a Ready or a
//   Done, and checks the held command fields while a command is outstanding.
module tb_backend_cmd_arbiter;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic        owner;
        logic [1:0]  cmd;
        logic [31:0] paddr;
        logic [31:0] cur;
        logic [31:0] rem;
    } rec_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  A_Command = '0, B_Command = '0;
    logic [31:0] A_PAddr = '0, B_PAddr = '0;
    logic [31:0] A_CurrentLeaf = '0, B_CurrentLeaf = '0;
    logic [31:0] A_RemappedLeaf = '0, B_RemappedLeaf = '0;
    logic        A_Valid = 1'b0, B_Valid = 1'b0, B_Pause = 1'b0;
    logic        A_Ready, B_Ready, A_Done, B_Done;
    logic [1:0]  Command;
    logic [31:0] PAddr, CurrentLeaf, RemappedLeaf;
    logic        CommandRequest, Owner;
    logic        CommandDone = 1'b0;

    backend_cmd_arbiter #(
        .BECMDWidth(2), .ORAMU(32), .ORAML(32), .StarveLimit(LIMIT)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .A_Command(A_Command), .A_PAddr(A_PAddr), .A_CurrentLeaf(A_CurrentLeaf),
        .A_RemappedLeaf(A_RemappedLeaf), .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Done(A_Done),
        .B_Command(B_Command), .B_PAddr(B_PAddr), .B_CurrentLeaf(B_CurrentLeaf),
        .B_RemappedLeaf(B_RemappedLeaf), .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Done(B_Done),
        .B_Pause(B_Pause),
        .Command(Command), .PAddr(PAddr), .CurrentLeaf(CurrentLeaf), .RemappedLeaf(RemappedLeaf),
        .CommandRequest(CommandRequest), .CommandDone(CommandDone), .Owner(Owner)
    );

    always #5 Clock = ~Clock;

    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit   m_busy = 0;       // a command is outstanding after the next edge
    bit   m_cur_busy = 0;   // a command is outstanding in the current cycle
    bit   m_owner = 0;
    int   m_starve = 0;
    bit   m_grant_a_last = 0;
    bit   m_grant_b_last = 0;
    rec_t grant_q[$];
    bit   done_q[$];
    bit   grant_log[$];

    // Monitor state
    rec_t cur_rec;
    bit   have_rec = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t rand_rec(input bit owner);
        rec_t r;
        r.owner = owner;
        r.cmd   = 2'($urandom);
        r.paddr = $urandom;
        r.cur   = $urandom;
        r.rem   = $urandom;
        return r;
    endfunction

    function automatic rec_t mk_rec(input bit owner, input logic [1:0] c,
                                    input logic [31:0] p, input logic [31:0] cl,
                                    input logic [31:0] rl);
        rec_t r;
        r.owner = owner; r.cmd = c; r.paddr = p; r.cur = cl; r.rem = rl;
        return r;
    endfunction

    // Transaction-level arbitration rules applied to the inputs of this cycle.
    task automatic model_eval(input rec_t fa, input rec_t fb);
        bit b_wants;
        m_cur_busy     = m_busy;
        m_grant_a_last = 0;
        m_grant_b_last = 0;
        if (Reset) begin
            m_busy   = 0;
            m_owner  = 0;
            m_starve = 0;
            return;
        end
        if (!m_busy) begin
            b_wants = B_Valid && !B_Pause;
            if (b_wants && (!A_Valid || m_starve == LIMIT)) begin
                grant_q.push_back(fb);
                m_owner = 1; m_starve = 0; m_busy = 1; m_grant_b_last = 1;
            end else if (A_Valid) begin
                grant_q.push_back(fa);
                m_owner = 0; m_busy = 1; m_grant_a_last = 1;
                if (b_wants && m_starve < LIMIT) m_starve++;
            end
        end else if (CommandDone) begin
            done_q.push_back(m_owner);
            m_busy = 0;
        end
    endtask

    task automatic drive_cycle(input bit av, input bit bv, input bit bp, input bit done,
                               input bit rst, input rec_t fa, input rec_t fb);
        @(posedge Clock);
        #1;
        A_Valid = av; B_Valid = bv; B_Pause = bp; CommandDone = done; Reset = rst;
        A_Command = fa.cmd; A_PAddr = fa.paddr; A_CurrentLeaf = fa.cur; A_RemappedLeaf = fa.rem;
        B_Command = fb.cmd; B_PAddr = fb.paddr; B_CurrentLeaf = fb.cur; B_RemappedLeaf = fb.rem;
        model_eval(fa, fb);
    endtask

    // Monitor: decoupled from stimulus, pops expectations on DUT events.
    initial begin
        rec_t r;
        forever begin
            @(negedge Clock);
            chk("cmd_request", CommandRequest, m_cur_busy);
            chk("ready_exclusive", A_Ready & B_Ready, 0);
            if (m_cur_busy && have_rec) begin
                chk("held_owner", Owner, cur_rec.owner);
                chk("held_command", Command, cur_rec.cmd);
                chk("held_paddr", PAddr, cur_rec.paddr);
                chk("held_curleaf", CurrentLeaf, cur_rec.cur);
                chk("held_remleaf", RemappedLeaf, cur_rec.rem);
            end
            if (A_Ready || B_Ready) begin
                grant_log.push_back(B_Ready);
                if (grant_q.size() == 0) begin
                    chk("unexpected_ready", {A_Ready, B_Ready}, 0);
                end else begin
                    r = grant_q.pop_front();
                    chk("grant_owner", B_Ready, r.owner);
                    cur_rec  = r;
                    have_rec = 1;
                end
            end
            if (A_Done || B_Done) begin
                chk("done_exclusive", A_Done & B_Done, 0);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", {A_Done, B_Done}, 0);
                end else begin
                    chk("done_owner", B_Done, done_q.pop_front());
                end
            end
        end
    end

    initial begin
        rec_t z, fa, fb;
        bit   av, bv, bp, dn, rs;
        int   busy_cnt, lat;
        z = '0;

        // Reset values
        drive_cycle(0, 0, 0, 0, 1, z, z);
        drive_cycle(0, 0, 0, 0, 1, z, z);
        drive_cycle(0, 0, 0, 0, 0, z, z);
        @(negedge Clock);
        chk("rst_request", CommandRequest, 0);
        chk("rst_owner", Owner, 0);
        chk("rst_fields", {Command, PAddr, CurrentLeaf, RemappedLeaf}, 0);
        chk("rst_ready_done", {A_Ready, B_Ready, A_Done, B_Done}, 0);

        // Single A command: granted at T, done at T+6, request drops at T+7
        fa = mk_rec(0, 2'd1, 32'h1234, 32'd5, 32'd9);
        drive_cycle(1, 0, 0, 0, 0, fa, z);
        @(negedge Clock);
        chk("t0_a_ready", A_Ready, 1);
        for (int i = 0; i < 5; i++) drive_cycle(0, 0, 0, 0, 0, fa, z);
        chk("t5_paddr", PAddr, 32'h1234);
        chk("t5_curleaf", CurrentLeaf, 32'd5);
        drive_cycle(0, 0, 0, 1, 0, fa, z);
        @(negedge Clock);
        chk("t6_a_done", A_Done, 1);
        drive_cycle(0, 0, 0, 0, 0, fa, z);
        @(negedge Clock);
        chk("t7_request", CommandRequest, 0);

        // Starvation: both valid continuously, B every LIMIT+1 grants
        drive_cycle(0, 0, 0, 0, 1, z, z);
        grant_log.delete();
        fa = rand_rec(0); fb = rand_rec(1);
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1, 1, 0, 0, 0, fa, fb);
            drive_cycle(1, 1, 0, 1, 0, fa, fb);
        end
        @(negedge Clock);
        chk("starve_log_len", grant_log.size(), 10);
        for (int k = 0; k < 10 && k < grant_log.size(); k++)
            chk($sformatf("starve_order_%0d", k), grant_log[k], ((k + 1) % (LIMIT + 1)) == 0);

        // B_Pause holds off B; release grants next cycle
        for (int i = 0; i < 20; i++) drive_cycle(0, 1, 1, 0, 0, z, fb);
        drive_cycle(0, 1, 0, 0, 0, z, fb);
        @(negedge Clock);
        chk("unpause_b_ready", B_Ready, 1);
        drive_cycle(0, 0, 0, 0, 0, z, fb);
        @(negedge Clock);
        chk("unpause_owner", Owner, 1);
        drive_cycle(0, 0, 0, 1, 0, z, fb);

        // CommandDone while idle is ignored
        drive_cycle(0, 0, 0, 1, 0, z, z);
        drive_cycle(0, 0, 0, 1, 0, z, z);

        // Reset two cycles after a B grant drops the command; pending A wins after
        fb = rand_rec(1); fa = rand_rec(0);
        drive_cycle(0, 1, 0, 0, 0, fa, fb);
        drive_cycle(1, 0, 0, 0, 0, fa, fb);
        drive_cycle(1, 0, 0, 1, 1, fa, fb);
        drive_cycle(1, 0, 0, 0, 0, fa, fb);
        @(negedge Clock);
        chk("post_rst_request", CommandRequest, 0);
        chk("post_rst_owner", Owner, 0);
        chk("post_rst_a_ready", A_Ready, 1);
        drive_cycle(0, 0, 0, 1, 0, fa, z);

        // Back-to-back: A valid during the Done cycle is granted next cycle
        drive_cycle(1, 0, 0, 0, 0, fa, z);
        drive_cycle(1, 0, 0, 1, 0, fa, z);
        @(negedge Clock);
        chk("b2b_no_ready_in_done", A_Ready, 0);
        drive_cycle(1, 0, 0, 0, 0, fa, z);
        @(negedge Clock);
        chk("b2b_ready_next", A_Ready, 1);
        drive_cycle(0, 0, 0, 1, 0, fa, z);

        // Randomized traffic
        av = 0; bv = 0; busy_cnt = 0; lat = 0;
        fa = rand_rec(0); fb = rand_rec(1);
        for (int i = 0; i < 3000; i++) begin
            if (!(av && !m_grant_a_last)) begin
                av = 1'($urandom_range(0, 1)); fa = rand_rec(0);
            end else if ($urandom_range(0, 9) == 0) av = 0;
            if (!(bv && !m_grant_b_last)) begin
                bv = 1'($urandom_range(0, 1)); fb = rand_rec(1);
            end else if ($urandom_range(0, 9) == 0) bv = 0;
            bp = ($urandom_range(0, 3) == 0);
            if (m_busy) begin
                dn = (busy_cnt >= lat);
                busy_cnt++;
            end else begin
                busy_cnt = 0;
                lat = $urandom_range(0, 4);
                dn = ($urandom_range(0, 19) == 0);
            end
            rs = ($urandom_range(0, 199) == 0);
            drive_cycle(av, bv, bp, dn, rs, fa, fb);
        end

        // Drain any outstanding command
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, m_busy, 0, z, z);
        @(negedge Clock);
        @(negedge Clock);
        chk("grant_q_empty", grant_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
